// File: rtl/viterbi_pkg.sv
// Shared constants and types for the K=3, rate-1/2 (7,5) Viterbi decoder datapath.
package viterbi_pkg;

    localparam int unsigned NUM_STATES = 4;
    localparam int unsigned BM_W       = 2;

    typedef logic [1:0] state_idx_t;

    // Codeword indices into the branch-metric vector, {c1, c0}.
    localparam logic [1:0] CW_00 = 2'b00;
    localparam logic [1:0] CW_01 = 2'b01;
    localparam logic [1:0] CW_10 = 2'b10;
    localparam logic [1:0] CW_11 = 2'b11;

endpackage

// File: rtl/acs_butterfly_cell.sv
// Combinational add-compare-select for one trellis state: two candidate paths in,
// survivor metric and decision out (tie keeps candidate A).
module acs_butterfly_cell
    import viterbi_pkg::*;
#(
    parameter int unsigned PM_W = 6
) (
    input  logic [PM_W-1:0] pm_a_i,
    input  logic [PM_W-1:0] pm_b_i,
    input  logic [BM_W-1:0] bm_a_i,
    input  logic [BM_W-1:0] bm_b_i,
    output logic [PM_W-1:0] pm_o,
    output logic            dec_o
);

    logic [PM_W-1:0] sum_a;
    logic [PM_W-1:0] sum_b;

    always_comb begin
        sum_a = pm_a_i + PM_W'(bm_a_i);
        sum_b = pm_b_i + PM_W'(bm_b_i);
        dec_o = (sum_b < sum_a);
        pm_o  = dec_o ? sum_b : sum_a;
    end

endmodule

// File: rtl/add_compare_select_unit.sv
// Radix-2 ACS stage: four butterflies, MSB-clear normalization, argmin of the new
// metrics and registered decision/metric outputs, one trellis step per valid cycle.
module add_compare_select_unit
    import viterbi_pkg::*;
#(
    parameter int unsigned PM_W    = 6,
    parameter int unsigned INIT_PM = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_valid,
    input  logic [1:0]      i_bm_0,
    input  logic [1:0]      i_bm_1,
    input  logic [1:0]      i_bm_2,
    input  logic [1:0]      i_bm_3,
    output logic            o_valid,
    output logic [3:0]      o_decision,
    output logic [PM_W-1:0] o_pm_0,
    output logic [PM_W-1:0] o_pm_1,
    output logic [PM_W-1:0] o_pm_2,
    output logic [PM_W-1:0] o_pm_3,
    output logic [1:0]      o_best_state,
    output logic            o_norm
);

    localparam logic [PM_W-1:0] INIT_V = PM_W'(INIT_PM);

    logic [BM_W-1:0]       bm     [NUM_STATES];
    logic [PM_W-1:0]       pm_q   [NUM_STATES];
    logic [PM_W-1:0]       pm_old [NUM_STATES];
    logic [PM_W-1:0]       pm_sel [NUM_STATES];
    logic [PM_W-1:0]       pm_d   [NUM_STATES];
    logic [NUM_STATES-1:0] dec_d;
    logic [NUM_STATES-1:0] dec_q;
    logic                  norm_d;
    logic                  norm_q;
    state_idx_t            best_d;
    state_idx_t            best_q;
    logic                  valid_q;
    logic [PM_W-1:0]       min_pm;

    assign bm[0] = i_bm_0;
    assign bm[1] = i_bm_1;
    assign bm[2] = i_bm_2;
    assign bm[3] = i_bm_3;

    // A restart step uses the initial metrics as its old metrics.
    always_comb begin
        for (int unsigned i = 0; i < NUM_STATES; i++) begin
            if (i_start) begin
                pm_old[i] = (i == 0) ? '0 : INIT_V;
            end else begin
                pm_old[i] = pm_q[i];
            end
        end
    end

    // Predecessors of state n are {n[0],0} (A) and {n[0],1} (B).
    acs_butterfly_cell #(.PM_W(PM_W)) u_acs_s0 (
        .pm_a_i (pm_old[0]),
        .pm_b_i (pm_old[1]),
        .bm_a_i (bm[CW_00]),
        .bm_b_i (bm[CW_11]),
        .pm_o   (pm_sel[0]),
        .dec_o  (dec_d[0])
    );

    acs_butterfly_cell #(.PM_W(PM_W)) u_acs_s1 (
        .pm_a_i (pm_old[2]),
        .pm_b_i (pm_old[3]),
        .bm_a_i (bm[CW_10]),
        .bm_b_i (bm[CW_01]),
        .pm_o   (pm_sel[1]),
        .dec_o  (dec_d[1])
    );

    acs_butterfly_cell #(.PM_W(PM_W)) u_acs_s2 (
        .pm_a_i (pm_old[0]),
        .pm_b_i (pm_old[1]),
        .bm_a_i (bm[CW_11]),
        .bm_b_i (bm[CW_00]),
        .pm_o   (pm_sel[2]),
        .dec_o  (dec_d[2])
    );

    acs_butterfly_cell #(.PM_W(PM_W)) u_acs_s3 (
        .pm_a_i (pm_old[2]),
        .pm_b_i (pm_old[3]),
        .bm_a_i (bm[CW_01]),
        .bm_b_i (bm[CW_10]),
        .pm_o   (pm_sel[3]),
        .dec_o  (dec_d[3])
    );

    always_comb begin
        norm_d = 1'b1;
        for (int unsigned i = 0; i < NUM_STATES; i++) begin
            norm_d = norm_d & pm_sel[i][PM_W-1];
        end
        for (int unsigned i = 0; i < NUM_STATES; i++) begin
            pm_d[i] = pm_sel[i];
            if (norm_d) begin
                pm_d[i][PM_W-1] = 1'b0;
            end
        end
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        best_d = '0;
        min_pm = pm_d[0];
        for (int unsigned i = 1; i < NUM_STATES; i++) begin
            if (pm_d[i] < min_pm) begin
                min_pm = pm_d[i];
                best_d = state_idx_t'(i);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NUM_STATES; i++) begin
                pm_q[i] <= (i == 0) ? '0 : INIT_V;
            end
            valid_q <= 1'b0;
            dec_q   <= '0;
            best_q  <= '0;
            norm_q  <= 1'b0;
        end else begin
            valid_q <= i_valid;
            if (i_valid) begin
                for (int unsigned i = 0; i < NUM_STATES; i++) begin
                    pm_q[i] <= pm_d[i];
                end
                dec_q  <= dec_d;
                best_q <= best_d;
                norm_q <= norm_d;
            end else if (i_start) begin
                for (int unsigned i = 0; i < NUM_STATES; i++) begin
                    pm_q[i] <= pm_old[i];
                end
            end
        end
    end

    assign o_valid      = valid_q;
    assign o_decision   = dec_q;
    assign o_best_state = best_q;
    assign o_norm       = norm_q;
    assign o_pm_0       = pm_q[0];
    assign o_pm_1       = pm_q[1];
    assign o_pm_2       = pm_q[2];
    assign o_pm_3       = pm_q[3];

endmodule

// File: tb/tb_add_compare_select_unit.sv
// Bench for add_compare_select_unit: directed trellis scenarios plus random steps,
// checked against a trellis-level reference model.
module tb_add_compare_select_unit;

    localparam int PM_W    = 6;
    localparam int INIT_PM = 4;
    localparam int HALF    = 1 << (PM_W - 1);

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b0;
    logic            i_start = 1'b0;
    logic            i_valid = 1'b0;
    logic [1:0]      i_bm_0 = '0;
    logic [1:0]      i_bm_1 = '0;
    logic [1:0]      i_bm_2 = '0;
    logic [1:0]      i_bm_3 = '0;
    logic            o_valid;
    logic [3:0]      o_decision;
    logic [PM_W-1:0] o_pm_0;
    logic [PM_W-1:0] o_pm_1;
    logic [PM_W-1:0] o_pm_2;
    logic [PM_W-1:0] o_pm_3;
    logic [1:0]      o_best_state;
    logic            o_norm;

    int errors = 0;
    int checks = 0;

    int       mpm[4];
    bit [3:0] mdec;
    int       mbest;
    bit       mnorm;
    bit       mvalid;

    add_compare_select_unit #(.PM_W(PM_W), .INIT_PM(INIT_PM)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_valid      (i_valid),
        .i_bm_0       (i_bm_0),
        .i_bm_1       (i_bm_1),
        .i_bm_2       (i_bm_2),
        .i_bm_3       (i_bm_3),
        .o_valid      (o_valid),
        .o_decision   (o_decision),
        .o_pm_0       (o_pm_0),
        .o_pm_1       (o_pm_1),
        .o_pm_2       (o_pm_2),
        .o_pm_3       (o_pm_3),
        .o_best_state (o_best_state),
        .o_norm       (o_norm)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] dut_pm(input int i);
        case (i)
            0:       return 32'(o_pm_0);
            1:       return 32'(o_pm_1);
            2:       return 32'(o_pm_2);
            default: return 32'(o_pm_3);
        endcase
    endfunction

    // Encoder output for input u leaving state s: {u^s1^s0, u^s0}.
    function automatic int cw(input int u, input int s);
        return (((u ^ (s >> 1) ^ s) & 1) << 1) | ((u ^ s) & 1);
    endfunction

    function automatic int hd(input int a, input int b);
        return ((a ^ b) & 1) + (((a ^ b) >> 1) & 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s.pm%0d", tag, i), dut_pm(i), 32'(mpm[i]));
        end
        chk({tag, ".valid"}, 32'(o_valid), 32'(mvalid));
        chk({tag, ".dec"}, 32'(o_decision), 32'(mdec));
        chk({tag, ".best"}, 32'(o_best_state), 32'(mbest));
        chk({tag, ".norm"}, 32'(o_norm), 32'(mnorm));
    endtask

    task automatic model_reset();
        mpm    = '{0, INIT_PM, INIT_PM, INIT_PM};
        mdec   = '0;
        mbest  = 0;
        mnorm  = 0;
        mvalid = 0;
    endtask

    // Each next state n is reached with input u = n[1] from states {n[0],0} and {n[0],1}.
    task automatic model_step(input bit st, input bit vl, input int b[4]);
        int base[4];
        int nxt[4];
        int u, pa, pb, ca, cb;
        bit all_hi;
        if (st) base = '{0, INIT_PM, INIT_PM, INIT_PM};
        else base = mpm;
        mvalid = vl;
        if (!vl) begin
            mpm = base;
            return;
        end
        mdec = '0;
        for (int n = 0; n < 4; n++) begin
            u  = n >> 1;
            pa = (n & 1) << 1;
            pb = pa | 1;
            ca = base[pa] + b[cw(u, pa)];
            cb = base[pb] + b[cw(u, pb)];
            if (cb < ca) begin
                nxt[n]  = cb;
                mdec[n] = 1'b1;
            end else begin
                nxt[n] = ca;
            end
        end
        all_hi = 1;
        for (int n = 0; n < 4; n++) if (nxt[n] < HALF) all_hi = 0;
        mnorm = all_hi;
        if (all_hi) for (int n = 0; n < 4; n++) nxt[n] -= HALF;
        mbest = 0;
        for (int n = 1; n < 4; n++) if (nxt[n] < nxt[mbest]) mbest = n;
        mpm = nxt;
    endtask

    task automatic step(input bit st, input bit vl, input int b0, input int b1,
                        input int b2, input int b3, input string tag);
        int b[4];
        b = '{b0, b1, b2, b3};
        @(negedge i_clk);
        i_start = st;
        i_valid = vl;
        i_bm_0  = 2'(b0);
        i_bm_1  = 2'(b1);
        i_bm_2  = 2'(b2);
        i_bm_3  = 2'(b3);
        @(posedge i_clk);
        #1;
        model_step(st, vl, b);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_start = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        int s, u, c, r, ncount;
        int bits[6];
        int exp_states[6];
        bits       = '{1, 0, 1, 1, 0, 0};
        exp_states = '{2, 1, 2, 3, 1, 0};

        // Received 00 after reset
        do_reset("rst0");
        #1 chk("pre_step.valid", 32'(o_valid), 32'd0);
        step(0, 1, 0, 1, 1, 2, "rx00");
        chk("rx00.pm0_c", 32'(o_pm_0), 32'd0);
        chk("rx00.pm1_c", 32'(o_pm_1), 32'd5);
        chk("rx00.pm2_c", 32'(o_pm_2), 32'd2);
        chk("rx00.pm3_c", 32'(o_pm_3), 32'd5);
        chk("rx00.dec_c", 32'(o_decision), 32'd0);
        chk("rx00.best_c", 32'(o_best_state), 32'd0);
        step(0, 0, 0, 1, 1, 2, "rx00_after");

        // Received 11 after reset
        do_reset("rst1");
        step(0, 1, 2, 1, 1, 0, "rx11");
        chk("rx11.pm2_c", 32'(o_pm_2), 32'd0);
        chk("rx11.pm1_c", 32'(o_pm_1), 32'd5);
        chk("rx11.best_c", 32'(o_best_state), 32'd2);

        // Error-free encoded stream: best state tracks the encoder with metric 0
        do_reset("rst2");
        s = 0;
        for (int k = 0; k < 6; k++) begin
            u = bits[k];
            c = cw(u, s);
            s = (u << 1) | (s >> 1);
            step(0, 1, hd(c, 0), hd(c, 1), hd(c, 2), hd(c, 3), $sformatf("enc%0d", k));
            chk($sformatf("enc%0d.state", k), 32'(o_best_state), 32'(exp_states[k]));
            chk($sformatf("enc%0d.win0", k), dut_pm(exp_states[k]), 32'd0);
        end

        // Uniform metrics climb until normalization
        do_reset("rst3");
        ncount = 0;
        for (int k = 0; k < 17; k++) begin
            step(0, 1, 2, 2, 2, 2, $sformatf("flat%0d", k));
            if (o_norm === 1'b1) ncount++;
        end
        chk("flat.norm_count", 32'(ncount), 32'd1);

        // Gaps, then restart with and without a step
        step(0, 1, 0, 1, 1, 2, "gap_a");
        step(0, 0, 2, 1, 1, 0, "gap_idle");
        step(0, 1, 1, 0, 2, 1, "gap_b");
        step(1, 1, 0, 1, 1, 2, "start_step");
        chk("start_step.pm1_c", 32'(o_pm_1), 32'd5);
        chk("start_step.pm2_c", 32'(o_pm_2), 32'd2);
        step(0, 1, 1, 2, 0, 1, "pre_load");
        step(1, 0, 2, 1, 1, 0, "start_load");
        chk("start_load.pm3_c", 32'(o_pm_3), 32'(INIT_PM));

        // Random received pairs, gaps and occasional restarts
        for (int k = 0; k < 300; k++) begin
            bit vl, st;
            vl = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 19) == 0);
            r  = $urandom_range(0, 3);
            step(st, vl, hd(r, 0), hd(r, 1), hd(r, 2), hd(r, 3), $sformatf("rnd%0d", k));
        end

        // Asynchronous reset between edges
        step(0, 1, 2, 1, 1, 0, "pre_async");
        #2;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step(0, 1, 0, 1, 1, 2, "post_async");
        chk("post_async.pm1_c", 32'(o_pm_1), 32'd5);
        chk("post_async.pm2_c", 32'(o_pm_2), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
